// File: rtl/board_ctrl.sv
// Tic-tac-toe board controller: button edge detection, cursor movement, move placement and win/draw detection.
// Optional BOARD_WIN_MASK_EN: when defined, win_mask marks the cells of the winning line(s); otherwise it is tied to 0.
module board_ctrl #(
    parameter logic [1:0] FIRST_MARK = 2'b01
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        btn_up,
    input  logic        btn_down,
    input  logic        btn_left,
    input  logic        btn_right,
    input  logic        btn_sel,
    output logic [17:0] board,
    output logic [3:0]  cursor,
    output logic [1:0]  turn,
    output logic [1:0]  winner,
    output logic        game_over,
    output logic [8:0]  win_mask,
    output logic [3:0]  move_count
);

    typedef enum logic [1:0] {PLAY, CHECK, WIN, DRAW} state_t;

    // Cell sets for rows, columns and diagonals; bit k is cell k.
    localparam logic [8:0] LINES [8] = '{
        9'b000000111, 9'b000111000, 9'b111000000,
        9'b001001001, 9'b010010010, 9'b100100100,
        9'b100010001, 9'b001010100
    };

    state_t      state_q, state_d;
    logic [4:0]  btn_q, btn_now, ev;
    logic [17:0] board_q, board_d;
    logic [3:0]  cursor_q, cursor_d;
    logic [1:0]  turn_q, turn_d;
    logic [1:0]  winner_q, winner_d;
    logic        game_over_q, game_over_d;
    logic [3:0]  move_count_q, move_count_d;
    logic [8:0]  own, hits;
`ifdef BOARD_WIN_MASK_EN
    logic [8:0]  win_mask_q, win_mask_d;
`endif

    assign btn_now = {btn_sel, btn_up, btn_down, btn_left, btn_right};
    assign ev      = btn_now & ~btn_q;

    always_comb begin
        own  = '0;
        hits = '0;
        for (int k = 0; k < 9; k++) begin
            own[k] = (board_q[2*k +: 2] == turn_q);
        end
        for (int l = 0; l < 8; l++) begin
            if ((own & LINES[l]) == LINES[l]) begin
                hits = hits | LINES[l];
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        board_d      = board_q;
        cursor_d     = cursor_q;
        turn_d       = turn_q;
        winner_d     = winner_q;
        game_over_d  = game_over_q;
        move_count_d = move_count_q;
`ifdef BOARD_WIN_MASK_EN
        win_mask_d   = win_mask_q;
`endif
        case (state_q)
            PLAY: begin
                if (ev[4]) begin
                    if (board_q[{cursor_q, 1'b0} +: 2] == 2'b00) begin
                        board_d[{cursor_q, 1'b0} +: 2] = turn_q;
                        move_count_d = move_count_q + 4'd1;
                        state_d      = CHECK;
                    end
                end else if (ev[3]) begin
                    cursor_d = (cursor_q < 4'd3) ? cursor_q + 4'd6 : cursor_q - 4'd3;
                end else if (ev[2]) begin
                    cursor_d = (cursor_q > 4'd5) ? cursor_q - 4'd6 : cursor_q + 4'd3;
                end else if (ev[1]) begin
                    cursor_d = (cursor_q inside {4'd0, 4'd3, 4'd6}) ? cursor_q + 4'd2 : cursor_q - 4'd1;
                end else if (ev[0]) begin
                    cursor_d = (cursor_q inside {4'd2, 4'd5, 4'd8}) ? cursor_q - 4'd2 : cursor_q + 4'd1;
                end
            end
            CHECK: begin
                // Only the mover can have completed a line, so turn_q is still the placed mark.
                if (|hits) begin
                    state_d     = WIN;
                    winner_d    = turn_q;
                    game_over_d = 1'b1;
`ifdef BOARD_WIN_MASK_EN
                    win_mask_d  = hits;
`endif
                end else if (move_count_q == 4'd9) begin
                    state_d     = DRAW;
                    winner_d    = 2'b11;
                    game_over_d = 1'b1;
                end else begin
                    state_d = PLAY;
                    turn_d  = turn_q ^ 2'b11;
                end
            end
            WIN, DRAW: begin
                if (ev[4]) begin
                    state_d      = PLAY;
                    board_d      = '0;
                    cursor_d     = 4'd4;
                    turn_d       = FIRST_MARK;
                    winner_d     = 2'b00;
                    game_over_d  = 1'b0;
                    move_count_d = 4'd0;
`ifdef BOARD_WIN_MASK_EN
                    win_mask_d   = '0;
`endif
                end
            end
            default: state_d = PLAY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            // Buttons load as pressed so a level held through reset yields no event.
            btn_q        <= '1;
            state_q      <= PLAY;
            board_q      <= '0;
            cursor_q     <= 4'd4;
            turn_q       <= FIRST_MARK;
            winner_q     <= 2'b00;
            game_over_q  <= 1'b0;
            move_count_q <= 4'd0;
        end else begin
            btn_q        <= btn_now;
            state_q      <= state_d;
            board_q      <= board_d;
            cursor_q     <= cursor_d;
            turn_q       <= turn_d;
            winner_q     <= winner_d;
            game_over_q  <= game_over_d;
            move_count_q <= move_count_d;
        end
    end

`ifdef BOARD_WIN_MASK_EN
    always_ff @(posedge clk) begin
        if (rst) win_mask_q <= '0;
        else     win_mask_q <= win_mask_d;
    end
    assign win_mask = win_mask_q;
`else
    assign win_mask = '0;
`endif

    assign board      = board_q;
    assign cursor     = cursor_q;
    assign turn       = turn_q;
    assign winner     = winner_q;
    assign game_over  = game_over_q;
    assign move_count = move_count_q;

endmodule

// File: tb/tb_board_ctrl.sv
// Bench for board_ctrl: directed game scenarios plus random button presses checked against a cell-array game model.
module tb_board_ctrl;

    localparam logic [1:0] FM = 2'b01;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [4:0]  btnv = 5'b0;   // {sel, up, down, left, right}
    logic [17:0] board;
    logic [3:0]  cursor;
    logic [1:0]  turn, winner;
    logic        game_over;
    logic [8:0]  win_mask;
    logic [3:0]  move_count;

    int n_asserts = 0;
    int n_fail    = 0;

    board_ctrl #(.FIRST_MARK(FM)) dut (
        .clk        (clk),
        .rst        (rst),
        .btn_up     (btnv[3]),
        .btn_down   (btnv[2]),
        .btn_left   (btnv[1]),
        .btn_right  (btnv[0]),
        .btn_sel    (btnv[4]),
        .board      (board),
        .cursor     (cursor),
        .turn       (turn),
        .winner     (winner),
        .game_over  (game_over),
        .win_mask   (win_mask),
        .move_count (move_count)
    );

    always #5 clk = ~clk;

    // Game model
    logic [1:0] bm [9];
    int         cur, cnt;
    logic [1:0] trn, win;
    logic [8:0] wm;
    bit         over;
    int         LN [8][3] = '{'{0,1,2}, '{3,4,5}, '{6,7,8}, '{0,3,6},
                              '{1,4,7}, '{2,5,8}, '{0,4,8}, '{2,4,6}};

    task automatic m_reset();
        for (int k = 0; k < 9; k++) bm[k] = 2'b00;
        cur = 4; cnt = 0; trn = FM; win = 2'b00; wm = '0; over = 0;
    endtask

    task automatic m_apply(input logic [4:0] m);
        logic [8:0] h;
        if (over) begin
            if (m[4]) m_reset();
        end else if (m[4]) begin
            if (bm[cur] == 2'b00) begin
                bm[cur] = trn;
                cnt = cnt + 1;
                h = '0;
                for (int l = 0; l < 8; l++)
                    if (bm[LN[l][0]] == trn && bm[LN[l][1]] == trn && bm[LN[l][2]] == trn)
                        h = h | (9'd1 << LN[l][0]) | (9'd1 << LN[l][1]) | (9'd1 << LN[l][2]);
                if (h != 0) begin
                    win = trn; wm = h; over = 1;
                end else if (cnt == 9) begin
                    win = 2'b11; over = 1;
                end else begin
                    trn = (trn == 2'b01) ? 2'b10 : 2'b01;
                end
            end
        end else if (m[3]) cur = (cur + 6) % 9;
        else if (m[2]) cur = (cur + 3) % 9;
        else if (m[1]) cur = (cur / 3) * 3 + (cur % 3 + 2) % 3;
        else if (m[0]) cur = (cur / 3) * 3 + (cur % 3 + 1) % 3;
    endtask

    function automatic logic [17:0] m_board();
        logic [17:0] v;
        for (int k = 0; k < 9; k++) v[2*k +: 2] = bm[k];
        return v;
    endfunction

    task automatic chk(input string tag, input logic [17:0] obs, input logic [17:0] exp_v);
        n_asserts++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    task automatic check_all(input string tag);
        logic [8:0] exp_wm;
`ifdef BOARD_WIN_MASK_EN
        exp_wm = wm;
`else
        exp_wm = '0;
`endif
        chk({tag, ".board"},      board,                 m_board());
        chk({tag, ".cursor"},     18'(cursor),           18'(cur));
        chk({tag, ".turn"},       18'(turn),             18'(trn));
        chk({tag, ".winner"},     18'(winner),           18'(win));
        chk({tag, ".game_over"},  18'(game_over),        18'(over));
        chk({tag, ".move_count"}, 18'(move_count),       18'(cnt));
        chk({tag, ".win_mask"},   18'(win_mask),         18'(exp_wm));
    endtask

    task automatic press(input logic [4:0] m);
        @(negedge clk) btnv = m;
        @(negedge clk) btnv = 5'b0;
        @(negedge clk);
        @(negedge clk);
        m_apply(m);
        check_all("press");
    endtask

    task automatic do_reset();
        @(negedge clk) begin rst = 1'b1; btnv = 5'b0; end
        @(negedge clk);
        @(negedge clk) rst = 1'b0;
        m_reset();
    endtask

    task automatic goto_cell(input int t);
        for (int g = 0; g < 3 && (cur % 3) != (t % 3); g++) press(5'b00001);
        for (int g = 0; g < 3 && (cur / 3) != (t / 3); g++) press(5'b00100);
    endtask

    task automatic place(input int t);
        goto_cell(t);
        press(5'b10000);
    endtask

    initial begin
        do_reset();
        check_all("reset");

        // Cursor walk 4 -> 5 -> 3 -> 6
        press(5'b00001);
        chk("walk1", 18'(cursor), 18'd5);
        press(5'b00001);
        chk("walk2", 18'(cursor), 18'd3);
        press(5'b00100);
        chk("walk3", 18'(cursor), 18'd6);
        press(5'b01000);
        press(5'b01000);
        press(5'b01000);
        press(5'b00010);
        press(5'b00010);
        goto_cell(4);

        // up + sel together: sel wins
        press(5'b11000);
        chk("upsel.cell4", 18'(board[9:8]), 18'd1);
        chk("upsel.turn", 18'(turn), 18'd2);

        // X row 0 win, with a sel on an occupied cell mid-game
        do_reset();
        place(0); place(3); place(1);
        goto_cell(0);
        press(5'b10000);
        chk("occupied.count", 18'(move_count), 18'd3);
        place(4); place(2);
        chk("rowwin.winner", 18'(winner), 18'd1);
        chk("rowwin.over", 18'(game_over), 18'd1);
`ifdef BOARD_WIN_MASK_EN
        chk("rowwin.mask", 18'(win_mask), 18'b000000111);
`else
        chk("rowwin.mask", 18'(win_mask), 18'd0);
`endif
        press(5'b00001);
        press(5'b10000);
        chk("newgame.board", board, 18'd0);
        chk("newgame.cursor", 18'(cursor), 18'd4);

        // Draw: X O X / X O O / O X X, with a direction press landing in CHECK
        place(0); place(1); place(2); place(4); place(3); place(5); place(7);
        goto_cell(6);
        @(negedge clk) btnv = 5'b10000;
        @(negedge clk) btnv = 5'b00001;
        @(negedge clk) btnv = 5'b00000;
        @(negedge clk);
        m_apply(5'b10000);
        check_all("check_discard");
        place(8);
        chk("draw.count", 18'(move_count), 18'd9);
        chk("draw.winner", 18'(winner), 18'd3);
        chk("draw.over", 18'(game_over), 18'd1);
        press(5'b10000);

        // Reset during CHECK of a winning move abandons it
        place(0); place(3); place(1); place(4);
        goto_cell(2);
        @(negedge clk) btnv = 5'b10000;
        @(negedge clk) begin btnv = 5'b0; rst = 1'b1; end
        @(negedge clk) rst = 1'b0;
        @(negedge clk);
        m_reset();
        check_all("rst_in_check");

        // sel held through reset release produces no event
        @(negedge clk) begin rst = 1'b1; btnv = 5'b10000; end
        @(negedge clk);
        @(negedge clk) rst = 1'b0;
        m_reset();
        repeat (3) @(negedge clk);
        check_all("held_sel");
        btnv = 5'b0;
        repeat (2) @(negedge clk);
        check_all("held_release");
        press(5'b10000);
        chk("held_repress.cell4", 18'(board[9:8]), 18'(FM));

        // Random presses
        for (int i = 0; i < 300; i++) begin
            logic [4:0] m;
            m = 5'($urandom_range(1, 31));
            if ($urandom_range(0, 2) != 0) m[4] = 1'b0;
            press(m);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
